// File: rtl/bist_pkg.sv
// Shared definitions for the march-test BIST controller and its memory responder.
// Direction encoding and default address width.
package bist_pkg;
    localparam int BIST_ADDR_W = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/bist_addr_cnt.sv
// Up/down address counter with reset > preset > en priority.
// carry flags the terminal count for the current direction.
module bist_addr_cnt
    import bist_pkg::*;
#(
    parameter int ADDR_W = BIST_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reset,
    input  logic              preset,
    input  logic              en,
    input  logic              up_down,
    output logic [ADDR_W-1:0] addr,
    output logic              carry
);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_next;
    logic              w_at_top;
    logic              w_at_bot;

    assign w_at_top = (r_addr == ADDR_MAX);
    assign w_at_bot = (r_addr == '0);

    always_comb begin
        w_next = r_addr;
        if (reset) begin
            w_next = '0;
        end else if (preset) begin
            w_next = ADDR_MAX;
        end else if (en) begin
            // Modular arithmetic gives the wrap in both directions.
            if (up_down == DIR_UP) begin
                w_next = r_addr + ADDR_ONE;
            end else begin
                w_next = r_addr - ADDR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
        end else begin
            r_addr <= w_next;
        end
    end

    assign addr  = r_addr;
    assign carry = en & (((up_down == DIR_UP) & w_at_top)
                       | ((up_down == DIR_DOWN) & w_at_bot));
endmodule

// File: rtl/bist_mem_responder.sv
// Memory-side BIST responder: address counter, 1-bit test RAM with a
// stuck-at fault injector, and a one-deep pipelined read-compare stage.
module bist_mem_responder
    import bist_pkg::*;
#(
    parameter int ADDR_W = BIST_ADDR_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reset,
    input  logic              preset,
    input  logic              en,
    input  logic              up_down,
    input  logic              read,
    input  logic              write,
    input  logic              data,
    output logic              carry,
    output logic              is_equal,
    output logic [ADDR_W-1:0] addr,
    output logic              proto_err,
    input  logic              flt_en,
    input  logic [ADDR_W-1:0] flt_addr,
    input  logic              flt_val
);
    logic [ADDR_W-1:0] w_addr;
    logic              w_hit;
    logic              w_rd;
    logic              w_wr;
    logic              w_wdata;
    logic              w_rdata;

    logic [DEPTH-1:0]  r_mem;
    logic              r_pend;
    logic              r_rdata;
    logic              r_exp;
    logic              r_is_eq;
    logic              r_proto;

    bist_addr_cnt #(
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .reset   (reset),
        .preset  (preset),
        .en      (en),
        .up_down (up_down),
        .addr    (w_addr),
        .carry   (carry)
    );

    // The faulty cell is stuck on both the write and the read path.
    assign w_hit   = flt_en & (w_addr == flt_addr);
    assign w_rd    = read & ~write;
    assign w_wr    = write & ~read;
    assign w_wdata = w_hit ? flt_val : data;
    assign w_rdata = w_hit ? flt_val : r_mem[w_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem   <= '0;
            r_pend  <= 1'b0;
            r_rdata <= 1'b0;
            r_exp   <= 1'b0;
            r_is_eq <= 1'b1;
            r_proto <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[w_addr] <= w_wdata;
            end
            r_pend <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rdata;
                r_exp   <= data;
            end
            r_is_eq <= r_pend ? (r_rdata == r_exp) : 1'b1;
            if (read & write) begin
                r_proto <= 1'b1;
            end
        end
    end

    assign addr      = w_addr;
    assign is_equal  = r_is_eq;
    assign proto_err = r_proto;
endmodule

// File: tb/tb_bist_mem_responder.sv
// Directed self-checking bench for bist_mem_responder.
// One task per scenario, each with its own inline comparisons.
module tb_bist_mem_responder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       reset = 1'b0;
    logic       preset = 1'b0;
    logic       en = 1'b0;
    logic       up_down = 1'b1;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic       data = 1'b0;
    logic       carry;
    logic       is_equal;
    logic [3:0] addr;
    logic       proto_err;
    logic       flt_en = 1'b0;
    logic [3:0] flt_addr = 4'd0;
    logic       flt_val = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    bist_mem_responder #(.ADDR_W(4), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .reset     (reset),
        .preset    (preset),
        .en        (en),
        .up_down   (up_down),
        .read      (read),
        .write     (write),
        .data      (data),
        .carry     (carry),
        .is_equal  (is_equal),
        .addr      (addr),
        .proto_err (proto_err),
        .flt_en    (flt_en),
        .flt_addr  (flt_addr),
        .flt_val   (flt_val)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; preset = 0; en = 0; read = 0; write = 0; data = 0;
    endtask

    task automatic do_rst();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_rst();
        #1;
        n_vec++;
        if (addr !== 4'd0) begin
            $display("FAIL reset_addr got=%0d exp=0", addr); n_err++;
        end
        n_vec++;
        if (is_equal !== 1'b1) begin
            $display("FAIL reset_is_equal got=%b exp=1", is_equal); n_err++;
        end
        n_vec++;
        if (proto_err !== 1'b0) begin
            $display("FAIL reset_proto_err got=%b exp=0", proto_err); n_err++;
        end
        n_vec++;
        if (carry !== 1'b0) begin
            $display("FAIL reset_carry got=%b exp=0", carry); n_err++;
        end
    endtask

    task automatic test_count_up();
        do_rst();
        reset = 1;
        tick();
        reset = 0; en = 1; up_down = 1;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_vec++;
            if (addr !== 4'(i) || carry !== (i == 15)) begin
                $display("FAIL count_up i=%0d got addr=%0d carry=%b exp addr=%0d carry=%b",
                         i, addr, carry, i, (i == 15));
                n_err++;
            end
            tick();
        end
        n_vec++;
        if (addr !== 4'd0) begin
            $display("FAIL count_up_wrap got=%0d exp=0", addr); n_err++;
        end
        idle();
    endtask

    task automatic test_count_down();
        preset = 1;
        tick();
        preset = 0; en = 1; up_down = 0;
        for (int i = 15; i >= 0; i--) begin
            #1;
            n_vec++;
            if (addr !== 4'(i) || carry !== (i == 0)) begin
                $display("FAIL count_down i=%0d got addr=%0d carry=%b exp addr=%0d carry=%b",
                         i, addr, carry, i, (i == 0));
                n_err++;
            end
            tick();
        end
        n_vec++;
        if (addr !== 4'd15) begin
            $display("FAIL count_down_wrap got=%0d exp=15", addr); n_err++;
        end
        reset = 1; preset = 1; en = 1;
        tick();
        n_vec++;
        if (addr !== 4'd0) begin
            $display("FAIL load_priority got=%0d exp=0", addr); n_err++;
        end
        idle();
        up_down = 1;
        #1;
        n_vec++;
        if (carry !== 1'b0) begin
            $display("FAIL carry_no_en got=%b exp=0", carry); n_err++;
        end
    endtask

    // One march element over all 16 cells; faulty is the stuck-at-0 cell 5.
    task automatic run_phase(input bit up, input bit rd, input bit d,
                             input bit fault, inout int zeros);
        int a;
        bit prev_v;
        bit prev_exp;
        idle();
        if (up) reset = 1; else preset = 1;
        tick();
        reset = 0; preset = 0;
        en = 1; up_down = up; read = rd; write = !rd; data = d;
        a = up ? 0 : 15;
        prev_v = 0;
        prev_exp = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (rd) begin
                n_vec++;
                if (is_equal !== prev_exp) begin
                    $display("FAIL march_cmp rd=%b d=%b got=%b exp=%b",
                             rd, d, is_equal, prev_exp);
                    n_err++;
                end
                if (is_equal === 1'b0) zeros++;
            end
            prev_v = 1;
            prev_exp = !(fault && d && a == 5);
            a = up ? (a + 1) % 16 : (a + 15) % 16;
        end
        idle();
        tick();
        if (rd && prev_v) begin
            n_vec++;
            if (is_equal !== prev_exp) begin
                $display("FAIL march_last got=%b exp=%b", is_equal, prev_exp);
                n_err++;
            end
            if (is_equal === 1'b0) zeros++;
        end
    endtask

    task automatic test_march_clean();
        int z;
        z = 0;
        do_rst();
        run_phase(1, 0, 0, 0, z);
        run_phase(0, 1, 0, 0, z);
        run_phase(1, 0, 1, 0, z);
        run_phase(1, 1, 1, 0, z);
        n_vec++;
        if (z != 0 || proto_err !== 1'b0) begin
            $display("FAIL march_clean got zeros=%0d proto=%b exp zeros=0 proto=0",
                     z, proto_err);
            n_err++;
        end
    endtask

    task automatic test_stuck_at0();
        int z;
        int zr0;
        z = 0;
        do_rst();
        flt_en = 1; flt_addr = 4'd5; flt_val = 0;
        run_phase(1, 0, 0, 1, z);
        run_phase(0, 1, 0, 1, z);
        zr0 = z;
        run_phase(1, 0, 1, 1, z);
        run_phase(1, 1, 1, 1, z);
        n_vec++;
        if (zr0 != 0 || z != 1) begin
            $display("FAIL stuck_at0 got r0_zeros=%0d total=%0d exp 0 and 1", zr0, z);
            n_err++;
        end
        flt_en = 0;
    endtask

    task automatic test_proto_err();
        do_rst();
        reset = 1;
        tick();
        reset = 0; en = 1; up_down = 1;
        tick(); tick(); tick();
        idle();
        read = 1; write = 1; data = 1;
        tick();
        idle();
        n_vec++;
        if (proto_err !== 1'b1 || addr !== 4'd3) begin
            $display("FAIL proto_set got proto=%b addr=%0d exp 1 and 3", proto_err, addr);
            n_err++;
        end
        read = 1; data = 0;
        tick();
        idle();
        tick();
        n_vec++;
        if (is_equal !== 1'b1) begin
            $display("FAIL proto_ram_unchanged got=%b exp=1", is_equal); n_err++;
        end
        read = 1; data = 1;
        tick();
        idle();
        tick();
        n_vec++;
        if (is_equal !== 1'b0 || proto_err !== 1'b1) begin
            $display("FAIL proto_sticky got eq=%b proto=%b exp 0 and 1", is_equal, proto_err);
            n_err++;
        end
        tick();
        n_vec++;
        if (is_equal !== 1'b1) begin
            $display("FAIL eq_return got=%b exp=1", is_equal); n_err++;
        end
        do_rst();
        n_vec++;
        if (proto_err !== 1'b0) begin
            $display("FAIL proto_clear got=%b exp=0", proto_err); n_err++;
        end
    endtask

    task automatic test_reset_mid_compare();
        do_rst();
        write = 1; data = 1;
        tick();
        idle();
        read = 1; data = 0; en = 1; up_down = 1;
        tick();
        idle();
        rst = 1;
        tick();
        rst = 0;
        n_vec++;
        if (is_equal !== 1'b1 || addr !== 4'd0) begin
            $display("FAIL rst_flush got eq=%b addr=%0d exp 1 and 0", is_equal, addr);
            n_err++;
        end
        read = 1; data = 0;
        tick();
        idle();
        tick();
        n_vec++;
        if (is_equal !== 1'b1) begin
            $display("FAIL rst_ram_clear got=%b exp=1", is_equal); n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_march_clean();
        test_stuck_at0();
        test_proto_err();
        test_reset_mid_compare();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bist_mem_responder.md
# bist_mem_responder

Memory-side responder for the march-test BIST controller: it owns the address counter, a 1-bit-wide test RAM and the read-compare logic. It consumes the controller's counter controls (`reset`, `preset`, `en`, `up_down`) and access controls (`read`, `write`, `data`). It returns `carry` (terminal count) and `is_equal` (read-compare result). A stuck-at fault injector lets the bench prove that the controller's `fail` path works.

## Interface
Parameters:
- `ADDR_W`, 4 — address counter width.
- `DEPTH`, 2**ADDR_W — number of 1-bit RAM words. Must equal 2**ADDR_W.

Ports:
- `clk` input 1 — single clock. Everything is rising-edge.
- `rst` input 1 — synchronous, active-high reset.
- `reset` input 1 — load the address counter with 0.
- `preset` input 1 — load the address counter with DEPTH-1.
- `en` input 1 — count enable.
- `up_down` input 1 — count direction: 1 = increment, 0 = decrement.
- `read` input 1 — read the RAM at the current address.
- `write` input 1 — write `data` to the RAM at the current address.
- `data` input 1 — write data, and expected data for a read.
- `carry` output 1 — terminal count reached.
- `is_equal` output 1 — 1 unless the last completed read mismatched.
- `addr` output ADDR_W — current counter value, for debug.
- `proto_err` output 1 — sticky flag: `read` and `write` were asserted together.
- `flt_en` input 1 — enable the stuck-at fault.
- `flt_addr` input ADDR_W — faulty cell address.
- `flt_val` input 1 — stuck value of the faulty cell.

## Operation
- **Reset.** On `rst`, at the clock edge:
  - `addr` = 0, every RAM word = 0, the compare pipeline is empty.
  - Outputs after reset: `is_equal` = 1, `proto_err` = 0.
  - `carry` follows its combinational definition and is 0 after reset while `en` = 0.
- **Address counter.** Priority, evaluated at each edge, highest first: `rst` > `reset` > `preset` > `en`.
  - With `en`, `addr` moves by ±1 per `up_down`.
  - Wrap-around is modular: DEPTH-1+1 → 0 and 0-1 → DEPTH-1.
- **carry.** Combinational: `en` & ((`up_down` & `addr` == DEPTH-1) | (!`up_down` & `addr` == 0)).
  - It is never asserted while `en` = 0.
  - `reset`/`preset` do not mask it; it reflects the pre-edge `addr`.
- **Access address.** Every access uses the pre-edge `addr`. A counter update on the same edge does not affect that cycle's access.
- **Write.** If `write` & !`read`: RAM[`addr`] <= `data`, except when `flt_en` & `addr` == `flt_addr`, in which case `flt_val` is stored.
- **Fault read-back.** The fault also applies on read-out: when `flt_en` is set, RAM[`flt_addr`] reads as `flt_val` regardless of its stored contents. This models a true stuck-at cell.
- **Read.** If `read` & !`write`, the responder captures rdata = RAM[`addr`] and exp = `data` into a one-deep compare stage, and sets pend = 1.
  - On the next edge, `is_equal` <= (rdata == exp).
  - If no compare is pending, `is_equal` <= 1.
- **Simultaneous read and write.** No access is performed, `proto_err` <= 1 (sticky until `rst`), and any pending compare still completes.
- **Back-to-back reads.** Fully pipelined. A read issued every cycle yields one `is_equal` result per cycle.

## Timing
- **carry:** 0-cycle, combinational from `en`/`up_down`/`addr`.
- **Write:** visible to a read issued on the next cycle (write-then-read at the same address returns the new value).
- **Read compare:** the read is issued at edge N, the data is registered at edge N, and `is_equal` is valid after edge N+1 for one cycle. It returns to 1 after edge N+2 unless a further read is pending.
- **Counter load/count:** `addr` is valid after the edge.
- **Reset mid-operation:** `rst` in any cycle flushes the pending compare. `is_equal` = 1 the cycle after, regardless of any in-flight mismatch.

## Structure
- Shared package `bist_pkg`: the direction encoding constants `DIR_UP` = 1 and `DIR_DOWN` = 0, and the default `ADDR_W`. The controller and responder both import it.
- One sub-module: `bist_addr_cnt` (up/down counter with reset/preset/en priority and `carry`).
- RAM, fault injector and compare stage stay inline in `bist_mem_responder`.

## Test plan
- **Counter up:** `rst`, `reset`, then `en`=1 and `up_down`=1 for 16 cycles with ADDR_W=4 → `addr` steps 0..15. `carry`=1 only while `addr`=15. `addr` wraps to 0.
- **Counter down:** `preset`, then `en`=1 and `up_down`=0 → `addr` 15..0. `carry`=1 only at `addr`=0. `reset`+`preset`+`en` together → `addr`=0.
- **Fault-free march:** write 0 to all 16 addresses up, read-expect-0 down, write 1 up, read-expect-1 up → `is_equal` stays 1 throughout and `proto_err`=0.
- **Stuck-at-0:** `flt_en`=1, `flt_addr`=5, `flt_val`=0, then the same march → `is_equal`=0 for exactly one cycle, one cycle after the r1 read at `addr`=5. All r0 reads pass.
- **Protocol error:** `read`=`write`=1 at `addr`=3 with `data`=1 → RAM[3] unchanged (a later read-expect-0 passes) and `proto_err`=1 until `rst`.
- **Reset mid-compare:** mismatching read at edge N, `rst` at edge N+1 → `is_equal`=1, `addr`=0 and RAM cleared after edge N+1.
